muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Multicycle sequencer for the MULT/MULTU-free signed MULT and DIV instructions of the CPU. It owns the iterative multiply/divide engine and the start/busy/done handshake with CtrlUnit.
- It drives the HI/LO write enables and data and reports divide-by-zero.
- It sits between registers A/B and HI/LO, replacing the separate mult/div instances and MuxMultOrDiv selection.

Parameters:
- WIDTH, 32, operand width in bits.
- ITERS, 32, iteration cycles per mult/div; must equal WIDTH.

Ports:
- clock  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- mult_start  in  1  request signed multiply of a_in*b_in.
- div_start  in  1  request signed divide a_in/b_in.
- a_in  in  WIDTH  operand A (register A output).
- b_in  in  WIDTH  operand B (register B output).
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- div_zero  out  1  one-cycle pulse, divisor was zero.
- hi_write  out  1  write enable for HI register.
- lo_write  out  1  write enable for LO register.
- hi_out  out  WIDTH  HI result (mult upper word / div remainder).
- lo_out  out  WIDTH  LO result (mult lower word / div quotient).

Behaviour:
- Timing reference: cycle 0 is the cycle a start is sampled high in IDLE.
- Reset:
  - state=IDLE, counter=0, all outputs 0, hi_out/lo_out=0.
  - Reset mid-operation aborts with no hi_write/lo_write/done pulse.
- States: IDLE, MULT, DIV, FINISH, DZERO.
- IDLE:
  - mult_start -> MULT.
  - div_start with b_in!=0 -> DIV.
  - div_start with b_in==0 -> DZERO.
  - a_in/b_in captured at the cycle-0 edge; later operand changes are ignored.
- Simultaneous mult_start and div_start: mult wins and div is dropped.
- Starts while busy are ignored; there is no queueing.
- MULT:
  - Radix-2 Booth on the signed 64-bit product, ITERS cycles (cycles 1..32), counter 0..31.
  - Counter==31 -> FINISH.
- DIV:
  - Restoring division on magnitudes, ITERS cycles, then FINISH.
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - Sign fixup is applied on entry to FINISH.
- FINISH (cycle 33):
  - done=1, hi_write=1, lo_write=1, hi_out/lo_out valid; next state IDLE.
- DZERO (cycle 1):
  - done=1, div_zero=1, hi_write=lo_write=0; HI/LO unchanged; next state IDLE.
- busy:
  - High in every non-IDLE state (cycles 1..33, or cycle 1 for DZERO).
  - Low in cycle 0; CtrlUnit must hold its wait state until done.
- hi_out/lo_out hold their last result after FINISH until the next FINISH.
- Edge cases:
  - Mult 0x80000000*0x80000000 -> HI=0x40000000, LO=0x00000000.
  - Div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0x00000000 (wraps, no exception).
- All arithmetic is WIDTH-bit two's complement; the product is 2*WIDTH bits with no overflow signal.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined:
  - mult with a_in==0 or b_in==0, or div with a_in==0 and b_in!=0, goes IDLE -> FINISH directly.
  - done is then at cycle 1 with HI=LO=0; busy is high in cycle 1 only.
- Undefined: every non-zero-divisor operation takes the full 33-cycle latency.
- Results are identical either way; only latency differs.

Decomposition:
- Package muldiv_pkg holds:
  - state encoding constants (IDLE=0, MULT=1, DIV=2, FINISH=3, DZERO=4, 3 bits);
  - WIDTH and ITERS defaults;
  - the counter width.
- One sub-module, muldiv_iter_unit, holds:
  - the shift/accumulator registers;
  - the Booth add/sub step and the restoring subtract step;
  - the sign fixup.
- It takes op-select and step-enable from the FSM in muldiv_sequencer and returns hi/lo.

Test Plan:
- Mult 7*-3: mult_start with a=0x00000007, b=0xFFFFFFFD -> done at cycle 33, HI=0xFFFFFFFF, LO=0xFFFFFFEB, hi_write/lo_write pulse 1 cycle, busy high cycles 1..33.
- Div -7/2: div_start with a=0xFFFFFFF9, b=0x00000002 -> cycle 33, LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Divide by zero: div_start with a=5, b=0 -> cycle 1 done=1, div_zero=1, no write enables, HI/LO keep previous values, IDLE at cycle 2.
- Conflicting starts: simultaneous mult_start and div_start with a=3, b=4 -> multiply result HI=0, LO=12. A div_start pulse at cycle 10 is ignored: one done only, at cycle 33.
- Reset mid-operation: reset at cycle 15 of a mult -> cycle 16 all outputs 0, no done. A new mult 2*2 then completes with LO=4.
- Early out: 0*0x12345678 -> with MULDIV_EARLY_OUT_EN, done at cycle 1 with HI=LO=0; without it, done at cycle 33 with the same values.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Purpose: shared constants and state encoding for the multiply/divide sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package muldiv_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_ITERS = 32;

   // Width of an iteration counter able to hold 0..iters-1.
   function automatic int cnt_width(input int iters);
      return (iters > 1) ? $clog2(iters) : 1;
   endfunction

   localparam int CNT_W = cnt_width(DEF_ITERS);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_MULT   = 3'd1,
      ST_DIV    = 3'd2,
      ST_FINISH = 3'd3,
      ST_DZERO  = 3'd4
   } state_t;

endpackage

// File: rtl/muldiv_iter_unit.sv
// Purpose: iterative datapath: radix-2 Booth multiply, restoring divide, sign fixup, HI/LO result registers.
// Latency: one step per enabled cycle; results land in o_hi/o_lo on the edge that retires the last step.
// Backpressure: none; the sequencer gates i_load/i_step and never overlaps operations.
module muldiv_iter_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             i_load,
   input  logic             i_op_div,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_step,
   input  logic             i_last,
   input  logic             i_clear,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo
);

   // r_acc is the Booth partial product (one guard bit so subtracting the most
   // negative multiplicand cannot overflow) or the division partial remainder.
   logic [WIDTH:0]   r_acc;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_m;
   logic             r_qm1;
   logic             r_op_div;
   logic             r_neg_q;
   logic             r_neg_r;

   logic [WIDTH:0]   w_m_ext;
   logic [WIDTH:0]   w_booth_sum;
   logic [WIDTH:0]   w_div_shift;
   logic [WIDTH:0]   w_div_trial;
   logic [WIDTH:0]   w_acc_nxt;
   logic [WIDTH-1:0] w_q_nxt;
   logic             w_qm1_nxt;
   logic [WIDTH-1:0] w_abs_a;
   logic [WIDTH-1:0] w_abs_b;
   logic [WIDTH-1:0] w_res_hi;
   logic [WIDTH-1:0] w_res_lo;

   // Magnitudes for division; 0x80..0 maps to itself, which is correct unsigned.
   assign w_abs_a = i_a[WIDTH-1] ? -i_a : i_a;
   assign w_abs_b = i_b[WIDTH-1] ? -i_b : i_b;

   // One Booth or restoring-divide step, plus sign fixup of the post-step values.
   always_comb begin
      w_m_ext     = {r_m[WIDTH-1], r_m};
      w_booth_sum = r_acc;
      w_div_shift = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
      w_div_trial = w_div_shift - {1'b0, r_m};
      w_acc_nxt   = r_acc;
      w_q_nxt     = r_q;
      w_qm1_nxt   = r_qm1;
      w_res_hi    = '0;
      w_res_lo    = '0;

      case ({r_q[0], r_qm1})
         2'b01:   w_booth_sum = r_acc + w_m_ext;
         2'b10:   w_booth_sum = r_acc - w_m_ext;
         default: w_booth_sum = r_acc;
      endcase

      if (r_op_div) begin
         if (!w_div_trial[WIDTH]) begin
            w_acc_nxt = w_div_trial;
            w_q_nxt   = {r_q[WIDTH-2:0], 1'b1};
         end else begin
            w_acc_nxt = w_div_shift;
            w_q_nxt   = {r_q[WIDTH-2:0], 1'b0};
         end
         w_res_lo = r_neg_q ? -w_q_nxt : w_q_nxt;
         w_res_hi = r_neg_r ? -w_acc_nxt[WIDTH-1:0] : w_acc_nxt[WIDTH-1:0];
      end else begin
         w_acc_nxt = {w_booth_sum[WIDTH], w_booth_sum[WIDTH:1]};
         w_q_nxt   = {w_booth_sum[0], r_q[WIDTH-1:1]};
         w_qm1_nxt = r_q[0];
         w_res_hi  = w_acc_nxt[WIDTH-1:0];
         w_res_lo  = w_q_nxt;
      end
   end

   // Working registers load on start and advance on each step; HI/LO update only on commit.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_acc    <= '0;
         r_q      <= '0;
         r_m      <= '0;
         r_qm1    <= 1'b0;
         r_op_div <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         o_hi     <= '0;
         o_lo     <= '0;
      end else begin
         if (i_load) begin
            r_op_div <= i_op_div;
            r_acc    <= '0;
            r_qm1    <= 1'b0;
            r_neg_q  <= i_a[WIDTH-1] ^ i_b[WIDTH-1];
            r_neg_r  <= i_a[WIDTH-1];
            if (i_op_div) begin
               r_q <= w_abs_a;
               r_m <= w_abs_b;
            end else begin
               r_q <= i_a;
               r_m <= i_b;
            end
         end else if (i_step) begin
            r_acc <= w_acc_nxt;
            r_q   <= w_q_nxt;
            r_qm1 <= w_qm1_nxt;
         end

         if (i_clear) begin
            o_hi <= '0;
            o_lo <= '0;
         end else if (i_step && i_last) begin
            o_hi <= w_res_hi;
            o_lo <= w_res_lo;
         end
      end
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// Purpose: start/busy/done sequencer for signed MULT/DIV driving HI/LO writes; MULDIV_EARLY_OUT_EN enables zero-operand shortcut.
// Latency: done at cycle ITERS+1 after the start cycle; cycle 1 for divide-by-zero (and zero operands with early-out).
// Backpressure: starts are accepted only in IDLE; starts while busy are dropped, the controller waits for done.
module muldiv_sequencer
   import muldiv_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int ITERS = DEF_ITERS
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             mult_start,
   input  logic             div_start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic             hi_write,
   output logic             lo_write,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out
);

   localparam int CW = cnt_width(ITERS);

   state_t        r_state;
   state_t        w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic          w_last_cnt;
   logic          w_b_zero;
   logic          w_load;
   logic          w_op_div;
   logic          w_step;
   logic          w_clear;

   assign w_last_cnt = (r_cnt == CW'(ITERS - 1));
   assign w_b_zero   = (b_in == '0);

   // State register and iteration counter; counter runs only while iterating.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if ((r_state == ST_MULT) || (r_state == ST_DIV)) begin
            r_cnt <= w_last_cnt ? '0 : r_cnt + CW'(1);
         end else begin
            r_cnt <= '0;
         end
      end
   end

   // Next-state decode, datapath controls and handshake outputs.
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_op_div    = 1'b0;
      w_step      = 1'b0;
      w_clear     = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      div_zero    = 1'b0;
      hi_write    = 1'b0;
      lo_write    = 1'b0;

      case (r_state)
         ST_IDLE: begin
            // Multiply has priority when both starts arrive together.
            if (mult_start) begin
`ifdef MULDIV_EARLY_OUT_EN
               if ((a_in == '0) || w_b_zero) begin
                  w_clear     = 1'b1;
                  w_state_nxt = ST_FINISH;
               end else begin
                  w_load      = 1'b1;
                  w_state_nxt = ST_MULT;
               end
`else
               w_load      = 1'b1;
               w_state_nxt = ST_MULT;
`endif
            end else if (div_start) begin
               w_op_div = 1'b1;
               if (w_b_zero) begin
                  w_state_nxt = ST_DZERO;
`ifdef MULDIV_EARLY_OUT_EN
               end else if (a_in == '0) begin
                  w_clear     = 1'b1;
                  w_state_nxt = ST_FINISH;
`endif
               end else begin
                  w_load      = 1'b1;
                  w_state_nxt = ST_DIV;
               end
            end
         end
         ST_MULT, ST_DIV: begin
            busy   = 1'b1;
            w_step = 1'b1;
            if (w_last_cnt) begin
               w_state_nxt = ST_FINISH;
            end
         end
         ST_FINISH: begin
            busy        = 1'b1;
            done        = 1'b1;
            hi_write    = 1'b1;
            lo_write    = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         ST_DZERO: begin
            busy        = 1'b1;
            done        = 1'b1;
            div_zero    = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   muldiv_iter_unit #(
      .WIDTH (WIDTH)
   ) u_iter (
      .clock    (clock),
      .reset    (reset),
      .i_load   (w_load),
      .i_op_div (w_op_div),
      .i_a      (a_in),
      .i_b      (b_in),
      .i_step   (w_step),
      .i_last   (w_last_cnt),
      .i_clear  (w_clear),
      .o_hi     (hi_out),
      .o_lo     (lo_out)
   );

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Purpose: directed bench for muldiv_sequencer with a queue-based done/result scoreboard.
// Latency: expectations carry the absolute cycle on which done must appear.
// Backpressure: stimulus waits for the scoreboard to drain before the next operation.
module tb_muldiv_sequencer;

   logic        clock;
   logic        reset;
   logic        mult_start;
   logic        div_start;
   logic [31:0] a_in;
   logic [31:0] b_in;
   logic        busy;
   logic        done;
   logic        div_zero;
   logic        hi_write;
   logic        lo_write;
   logic [31:0] hi_out;
   logic [31:0] lo_out;

`ifdef MULDIV_EARLY_OUT_EN
   localparam int EO_LAT = 1;
`else
   localparam int EO_LAT = 33;
`endif

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
      int          cyc;
      string       name;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   tb_cyc = 0;

   muldiv_sequencer dut (
      .clock      (clock),
      .reset      (reset),
      .mult_start (mult_start),
      .div_start  (div_start),
      .a_in       (a_in),
      .b_in       (b_in),
      .busy       (busy),
      .done       (done),
      .div_zero   (div_zero),
      .hi_write   (hi_write),
      .lo_write   (lo_write),
      .hi_out     (hi_out),
      .lo_out     (lo_out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) tb_cyc <= tb_cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got=%h want=%h (cycle %0d)", name, act, req, tb_cyc);
      end
   endtask

   // Monitor: every done pulse must match the oldest pending expectation.
   always @(negedge clock) begin
      exp_t e;
      if (!reset && done) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: got done=1 want done=0 (cycle %0d)", tb_cyc);
         end else begin
            e = exp_q.pop_front();
            chk({e.name, "_cycle"}, tb_cyc, e.cyc);
            chk({e.name, "_hi"}, hi_out, e.hi);
            chk({e.name, "_lo"}, lo_out, e.lo);
            chk({e.name, "_dz"}, {31'd0, div_zero}, {31'd0, e.dz});
            chk({e.name, "_wr"}, {30'd0, hi_write, lo_write}, e.dz ? 32'd0 : 32'd3);
         end
      end
   end

   // Drives one start pulse in cycle 0; returns #1 into cycle 1.
   task automatic drive(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
      @(posedge clock);
      #1;
      mult_start = m;
      div_start  = d;
      a_in       = a;
      b_in       = b;
      chk("busy_c0", {31'd0, busy}, 32'd0);
      @(posedge clock);
      #1;
      mult_start = 1'b0;
      div_start  = 1'b0;
      a_in       = $urandom;
      b_in       = $urandom;
      chk("busy_c1", {31'd0, busy}, 32'd1);
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clock);
         #1;
         n++;
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL %s_timeout: pending=%0d want=0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic op(input string name, input logic m, input logic d,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] hi, input logic [31:0] lo,
                     input logic dz, input int lat);
      exp_t e;
      @(negedge clock);
      e.hi   = hi;
      e.lo   = lo;
      e.dz   = dz;
      e.cyc  = tb_cyc + 1 + lat;
      e.name = name;
      exp_q.push_back(e);
      drive(m, d, a, b);
   endtask

   task automatic finish_op(input string name);
      drain(name);
      chk({name, "_busy_done"}, {31'd0, busy}, 32'd1);
      @(negedge clock);
      chk({name, "_busy_after"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      reset      = 1'b1;
      mult_start = 1'b0;
      div_start  = 1'b0;
      a_in       = '0;
      b_in       = '0;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_flags", {28'd0, done, div_zero, hi_write, lo_write}, 32'd0);
      chk("rst_hi", hi_out, 32'd0);
      chk("rst_lo", lo_out, 32'd0);
      reset = 1'b0;

      op("mul_7_m3", 1'b1, 1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33);
      finish_op("mul_7_m3");

      op("div_m7_2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33);
      finish_op("div_m7_2");

      // HI/LO keep the previous result on divide-by-zero.
      op("div_zero", 1'b0, 1'b1, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1, 1);
      finish_op("div_zero");

      // Simultaneous starts: multiply wins; a later div_start while busy is dropped.
      op("conflict", 1'b1, 1'b1, 32'h0000_0003, 32'h0000_0004, 32'h0000_0000, 32'h0000_000C, 1'b0, 33);
      repeat (9) @(posedge clock);
      #1;
      div_start = 1'b1;
      a_in      = 32'd100;
      b_in      = 32'd7;
      @(posedge clock);
      #1;
      div_start = 1'b0;
      finish_op("conflict");

      // Reset in cycle 15 of a multiply: everything clears, no done.
      drive(1'b1, 1'b0, 32'h0000_0005, 32'h0000_0006);
      repeat (14) @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_flags", {28'd0, done, div_zero, hi_write, lo_write}, 32'd0);
      chk("midrst_hi", hi_out, 32'd0);
      chk("midrst_lo", lo_out, 32'd0);

      op("mul_2_2", 1'b1, 1'b0, 32'd2, 32'd2, 32'h0000_0000, 32'h0000_0004, 1'b0, 33);
      finish_op("mul_2_2");

      op("mul_min_min", 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 33);
      finish_op("mul_min_min");

      op("div_min_m1", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 33);
      finish_op("div_min_m1");

      op("mul_max_max", 1'b1, 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 1'b0, 33);
      finish_op("mul_max_max");

      op("mul_m1_m1", 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 33);
      finish_op("mul_m1_m1");

      op("div_100_m7", 1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2, 1'b0, 33);
      finish_op("div_100_m7");

      op("div_m100_7", 1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0, 33);
      finish_op("div_m100_7");

      op("mul_zero", 1'b1, 1'b0, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 1'b0, EO_LAT);
      finish_op("mul_zero");

      op("div_zero_num", 1'b0, 1'b1, 32'h0000_0000, 32'd5, 32'h0000_0000, 32'h0000_0000, 1'b0, EO_LAT);
      finish_op("div_zero_num");

      repeat (5) @(posedge clock);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
